// File: rtl/arf062b064e1r1w0cbbehsaa4acw_pkg.sv
// Shared constants and types for the 62x64 1R1W latch register-file write scheduler.
package arf062b064e1r1w0cbbehsaa4acw_pkg;

   localparam int DEPTH  = 62;
   localparam int DWIDTH = 64;
   localparam int AWIDTH = 6;

   // One bit wider than an address so the legality compare never wraps.
   localparam logic [AWIDTH:0] DEPTH_LIM = (AWIDTH+1)'(DEPTH);

   // Winner held between grant and latch issue.
   typedef struct packed {
      logic              vld;
      logic [AWIDTH-1:0] addr;
      logic [DWIDTH-1:0] data;
   } wr_stage_t;

   // True when the address names a physical entry.
   function automatic logic addr_legal(input logic [AWIDTH-1:0] a);
      return ({1'b0, a} < DEPTH_LIM);
   endfunction

endpackage

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_rr_arb.sv
// NREQ-wide round-robin arbiter. Grant is combinational from req and the
// pointer; the pointer advances past the winner and holds otherwise.
module arf062b064e1r1w0cbbehsaa4acw_rr_arb #(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            hold,
   output logic [NREQ-1:0] gnt
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic [PW-1:0] win;
   logic [PW-1:0] idx;
   logic [PW:0]   sum;
   logic          found;

   // Search from ptr upward with wrap; no grant while held or in reset.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      sum   = '0;
      if (!hold && rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
               sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
               found    = 1'b1;
               gnt[idx] = 1'b1;
               win      = idx;
            end
         end
      end
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_wr_sched.sv
// Write-port scheduler for the 62x64 1R1W latch register file.
// Arbitrates NREQ writers, stages the winner for one cycle, then drives the
// active-low per-entry latch enables and shared latch data bus.
// Optional read write-through: define ARF062B064E1R1W0CBBEHSAA4ACW_RD_BYPASS_EN.
module arf062b064e1r1w0cbbehsaa4acw_wr_sched
   import arf062b064e1r1w0cbbehsaa4acw_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*AWIDTH-1:0] req_addr,
   input  logic [NREQ*DWIDTH-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   input  logic                   stall,
   output logic [DEPTH-1:0]       lat_en_b,
   output logic [DWIDTH-1:0]      lat_d,
   input  logic [AWIDTH-1:0]      rd_addr,
   input  logic [DWIDTH-1:0]      rd_arr_data,
   output logic [DWIDTH-1:0]      rd_data,
   output logic                   addr_err,
   input  logic                   err_clr
);

   logic [NREQ-1:0]   gnt;
   logic              any_gnt;
   logic [AWIDTH-1:0] win_addr;
   logic [DWIDTH-1:0] win_data;

   wr_stage_t         stage_q;
   wr_stage_t         stage_d;
   logic [DEPTH-1:0]  lat_en_b_q;
   logic [DEPTH-1:0]  lat_en_b_d;
   logic              addr_err_q;
   logic              addr_err_d;

   arf062b064e1r1w0cbbehsaa4acw_rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .hold  (stall),
      .gnt   (gnt)
   );

   assign req_ready = gnt;

   // One-hot grant selects the winning address and data.
   always_comb begin
      any_gnt  = 1'b0;
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            any_gnt  = 1'b1;
            win_addr = win_addr | req_addr[i*AWIDTH +: AWIDTH];
            win_data = win_data | req_data[i*DWIDTH +: DWIDTH];
         end
      end
   end

   // Stage update: freeze on stall, load on grant, otherwise empty out.
   // Address/data are kept when emptying so the data bus does not toggle.
   always_comb begin
      stage_d = stage_q;
      if (!stall) begin
         if (any_gnt) begin
            stage_d.vld  = 1'b1;
            stage_d.addr = win_addr;
            stage_d.data = win_data;
         end else begin
            stage_d.vld  = 1'b0;
         end
      end
   end

   // Decode the next stage into latch enables so they are ready as a flop
   // output for the issue cycle; illegal addresses open nothing.
   always_comb begin
      lat_en_b_d = '1;
      if (stage_d.vld && addr_legal(stage_d.addr)) begin
         lat_en_b_d[stage_d.addr] = 1'b0;
      end
   end

   // Sticky illegal-address flag; a new error beats a simultaneous clear.
   always_comb begin
      addr_err_d = (addr_err_q && !err_clr) || (any_gnt && !addr_legal(win_addr));
   end

   // Stage, latch-enable and error registers; reset closes every latch at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q    <= '0;
         lat_en_b_q <= '1;
         addr_err_q <= 1'b0;
      end else begin
         stage_q    <= stage_d;
         lat_en_b_q <= lat_en_b_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Stall must close the latches within the cycle it is raised, so it is
   // ORed onto the registered enables rather than waiting an edge.
   assign lat_en_b = lat_en_b_q | {DEPTH{stall}};
   assign lat_d    = stage_q.data;
   assign addr_err = addr_err_q;

`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_RD_BYPASS_EN
   // Write-through covers the window where the entry latch is open.
   always_comb begin
      rd_data = rd_arr_data;
      if (stage_q.vld && (rd_addr == stage_q.addr)) begin
         rd_data = stage_q.data;
      end
   end
`else
   logic unused_rd_addr;
   assign unused_rd_addr = ^rd_addr;

   // No forwarding: a same-cycle read sees the old array contents.
   always_comb begin
      rd_data = rd_arr_data;
   end
`endif

endmodule

// File: tb/tb_arf062b064e1r1w0cbbehsaa4acw_wr_sched.sv
// Directed bench for the latch register-file write scheduler.
module tb_arf062b064e1r1w0cbbehsaa4acw_wr_sched;

   localparam int NREQ = 4;
   localparam int AW   = 6;
   localparam int DW   = 64;
   localparam int DP   = 62;
   localparam logic [DP-1:0] ALL1 = {DP{1'b1}};

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 stall;
   logic [DP-1:0]        lat_en_b;
   logic [DW-1:0]        lat_d;
   logic [AW-1:0]        rd_addr;
   logic [DW-1:0]        rd_arr_data;
   logic [DW-1:0]        rd_data;
   logic                 addr_err;
   logic                 err_clr;

   int tests;
   int fails;

   logic [DW-1:0] mem [0:DP-1];

   arf062b064e1r1w0cbbehsaa4acw_wr_sched #(.NREQ(NREQ)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .stall       (stall),
      .lat_en_b    (lat_en_b),
      .lat_d       (lat_d),
      .rd_addr     (rd_addr),
      .rd_arr_data (rd_arr_data),
      .rd_data     (rd_data),
      .addr_err    (addr_err),
      .err_clr     (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Latch array model: open entries capture lat_d during the low phase.
   always @(negedge clk) begin
      for (int e = 0; e < DP; e++) begin
         if (!lat_en_b[e]) mem[e] <= lat_d;
      end
   end

   assign rd_arr_data = (rd_addr < 6'd62) ? mem[rd_addr] : 64'h0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setreq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   function automatic logic [DP-1:0] en_exp(input int entry);
      logic [DP-1:0] e;
      e        = ALL1;
      e[entry] = 1'b0;
      return e;
   endfunction

   initial begin
      tests     = 0;
      fails     = 0;
      rst_n     = 1'b0;
      stall     = 1'b0;
      err_clr   = 1'b0;
      rd_addr   = '0;
      req_valid = 4'hF;
      req_addr  = '0;
      req_data  = '0;
      for (int i = 0; i < NREQ; i++) setreq(i, 6'(10 + i), 64'h100 + 64'(i));

      // Reset with all requesters active
      tick();
      tick();
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_lat_en_b", 64'(lat_en_b), 64'(ALL1));
      chk("rst_lat_d", lat_d, 64'h0);
      chk("rst_addr_err", 64'(addr_err), 64'h0);
      rst_n = 1'b1;
      #1;
      chk("first_grant", 64'(req_ready), 64'h1);

      // Round robin over 8 cycles
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
         tick();
         chk($sformatf("rr_en_%0d", k), 64'(lat_en_b), 64'(en_exp(10 + (k % 4))));
         chk($sformatf("rr_d_%0d", k), lat_d, 64'h100 + 64'(k % 4));
      end
      req_valid = '0;
      tick();
      chk("rr_idle_en", 64'(lat_en_b), 64'(ALL1));

      // Write top entry, then read it back (ptr=0 -> req2 wins)
      setreq(2, 6'd61, 64'hA5A5_A5A5_A5A5_A5A5);
      req_valid = 4'b0100;
      #1;
      chk("w61_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      chk("w61_en", 64'(lat_en_b), 64'(en_exp(61)));
      chk("w61_d", lat_d, 64'hA5A5_A5A5_A5A5_A5A5);
      tick();
      rd_addr = 6'd61;
      #1;
      chk("w61_rd", rd_data, 64'hA5A5_A5A5_A5A5_A5A5);

      // Illegal address 62 (ptr=3, req0 wins by wrap)
      setreq(0, 6'd62, 64'h62);
      req_valid = 4'b0001;
      #1;
      chk("ill62_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      chk("ill62_en", 64'(lat_en_b), 64'(ALL1));
      chk("ill62_err", 64'(addr_err), 64'h1);
      // Clear together with a new bad address: set wins
      setreq(0, 6'd63, 64'h63);
      req_valid = 4'b0001;
      err_clr   = 1'b1;
      #1;
      chk("ill63_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      err_clr   = 1'b0;
      chk("ill63_err", 64'(addr_err), 64'h1);
      chk("ill63_en", 64'(lat_en_b), 64'(ALL1));
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_cleared", 64'(addr_err), 64'h0);

      // Stall after a grant (ptr=1 -> req1 wins)
      setreq(1, 6'd20, 64'hDEAD_BEEF);
      req_valid = 4'b0010;
      #1;
      chk("stall_grant", 64'(req_ready), 64'h2);
      tick();
      setreq(3, 6'd30, 64'h3333);
      req_valid = 4'b1000;
      stall     = 1'b1;
      #1;
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("stall_en_%0d", s), 64'(lat_en_b), 64'(ALL1));
         chk($sformatf("stall_ready_%0d", s), 64'(req_ready), 64'h0);
         tick();
      end
      stall     = 1'b0;
      req_valid = '0;
      #1;
      chk("unstall_en", 64'(lat_en_b), 64'(en_exp(20)));
      chk("unstall_d", lat_d, 64'hDEAD_BEEF);
      tick();
      chk("unstall_idle", 64'(lat_en_b), 64'(ALL1));
      rd_addr = 6'd20;
      #1;
      chk("unstall_rd", rd_data, 64'hDEAD_BEEF);

      // Bypass: preload entry 5, then write it while reading it (ptr=2)
      setreq(0, 6'd5, 64'h0BAD);
      req_valid = 4'b0001;
      #1;
      tick();
      req_valid = '0;
      tick();
      setreq(0, 6'd5, 64'h1234);
      req_valid = 4'b0001;
      rd_addr   = 6'd5;
      #1;
      tick();
      req_valid = '0;
      #1;
`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_RD_BYPASS_EN
      chk("bypass_rd", rd_data, 64'h1234);
`else
      chk("bypass_rd", rd_data, 64'h0BAD);
`endif
      tick();
      chk("bypass_after", rd_data, 64'h1234);

      // Back-to-back writes to entry 7 (ptr=1: req1 then req0)
      setreq(0, 6'd7, 64'h11);
      setreq(1, 6'd7, 64'h22);
      req_valid = 4'b0011;
      #1;
      chk("b2b_ready1", 64'(req_ready), 64'h2);
      tick();
      chk("b2b_en1", 64'(lat_en_b), 64'(en_exp(7)));
      chk("b2b_d1", lat_d, 64'h22);
      chk("b2b_ready0", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      chk("b2b_en0", 64'(lat_en_b), 64'(en_exp(7)));
      chk("b2b_d0", lat_d, 64'h11);
      tick();
      rd_addr = 6'd7;
      #1;
      chk("b2b_rd", rd_data, 64'h11);

      // Asynchronous reset with a write in the stage (ptr=1 -> req2)
      setreq(2, 6'd40, 64'h77);
      req_valid = 4'b0100;
      #1;
      tick();
      chk("midrst_en_pre", 64'(lat_en_b), 64'(en_exp(40)));
      rst_n = 1'b0;
      #1;
      chk("midrst_en", 64'(lat_en_b), 64'(ALL1));
      chk("midrst_d", lat_d, 64'h0);
      chk("midrst_ready", 64'(req_ready), 64'h0);
      req_valid = 4'hF;
      rst_n     = 1'b1;
      #1;
      chk("midrst_ptr", 64'(req_ready), 64'h1);
      req_valid = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
